// File: rtl/aqfp_excite_pkg.sv
// Shared configuration, state encoding and phase-offset helper for the AQFP
// excitation generator.
package aqfp_excite_pkg;

  localparam int NPHASE = 4;
  localparam int DIV    = 2;
  localparam int WARMUP = 8;
  localparam int CW     = 16;

  localparam int P      = NPHASE * DIV;
  localparam int HALF_P = P / 2;

  // Widths of the period tick and the warm-up/drain counter.
  localparam int TW = (P > 1) ? $clog2(P) : 1;
  localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DC_SETTLE,
    RUN,
    DRAIN
  } state_t;

  function automatic int phase_offset(input int k);
    return k * DIV;
  endfunction

endpackage

// File: rtl/aqfp_phase_slice.sv
// One excitation phase: sticky enable plus the mod-P half-period compare,
// evaluated on next-cycle values so the phase output is registered.
module aqfp_phase_slice
  import aqfp_excite_pkg::*;
#(
  parameter int OFFSET = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          run_next,
  input  logic [TW-1:0] t_next,
  output logic          xphase
);

  localparam int TW1 = TW + 1;
  localparam logic [TW:0] OFF_W  = TW1'(OFFSET);
  localparam logic [TW:0] P_W    = TW1'(P);
  localparam logic [TW:0] HALF_W = TW1'(HALF_P);

  logic          en_q;
  logic          en_n;
  logic          x_n;
  logic [TW:0]   t_ext;
  logic [TW:0]   diff;

  // The enable latches the first time the tick reaches this phase's offset and
  // is dropped as soon as the burst leaves RUN.
  always_comb begin
    t_ext = {1'b0, t_next};
    diff  = (t_ext >= OFF_W) ? (t_ext - OFF_W) : (t_ext + P_W - OFF_W);
    en_n  = run_next && (en_q || (t_ext == OFF_W));
    x_n   = en_n && (diff < HALF_W);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_q   <= 1'b0;
      xphase <= 1'b0;
    end else begin
      en_q   <= en_n;
      xphase <= x_n;
    end
  end

endmodule

// File: rtl/aqfp_excite_gen.sv
// Sequencer for AQFP bias: DC settle, a burst of multi-phase AC excitation
// periods with a per-period sample strobe, then a DC-only drain.
module aqfp_excite_gen
  import aqfp_excite_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [CW-1:0]     burst_len,
  output logic              dc_en,
  output logic [NPHASE-1:0] xphase,
  output logic              sample_strobe,
  output logic [CW-1:0]     cycle_cnt,
  output logic              busy,
  output logic              done
);

  localparam logic [TW-1:0] T_LAST = TW'(P - 1);
  localparam logic [WW-1:0] W_LAST = WW'(WARMUP - 1);

  state_t        state;
  state_t        state_n;
  logic [TW-1:0] tick;
  logic [TW-1:0] tick_n;
  logic [WW-1:0] wcnt;
  logic [WW-1:0] wcnt_n;
  logic [CW-1:0] blen;
  logic [CW-1:0] blen_n;
  logic [CW-1:0] cnt_n;
  logic [CW-1:0] cnt_inc;
  logic          stop_pend;
  logic          stop_n;
  logic          done_n;
  logic          run_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tick      <= '0;
      wcnt      <= '0;
      blen      <= '0;
      stop_pend <= 1'b0;
      cycle_cnt <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      tick      <= tick_n;
      wcnt      <= wcnt_n;
      blen      <= blen_n;
      stop_pend <= stop_n;
      cycle_cnt <= cnt_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    tick_n  = tick;
    wcnt_n  = wcnt;
    blen_n  = blen;
    stop_n  = stop_pend;
    cnt_n   = cycle_cnt;
    done_n  = 1'b0;
    cnt_inc = (&cycle_cnt) ? cycle_cnt : (cycle_cnt + 1'b1);

    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n = DC_SETTLE;
          blen_n  = burst_len;
          cnt_n   = '0;
          wcnt_n  = '0;
          stop_n  = 1'b0;
        end
      end
      DC_SETTLE: begin
        if (stop) begin
          state_n = DRAIN;
          wcnt_n  = '0;
        end else if (wcnt == W_LAST) begin
          state_n = RUN;
          tick_n  = '0;
        end else begin
          wcnt_n = wcnt + 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          stop_n = 1'b1;
        end
        // Periods always complete; stop and burst end are only honoured at the wrap.
        if (tick == T_LAST) begin
          cnt_n  = cnt_inc;
          tick_n = '0;
          if (stop || stop_pend || ((blen != '0) && (cnt_inc == blen))) begin
            state_n = DRAIN;
            wcnt_n  = '0;
            stop_n  = 1'b0;
          end
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      DRAIN: begin
        if (wcnt == W_LAST) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          wcnt_n = wcnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign run_next      = (state_n == RUN);
  assign busy          = (state != IDLE);
  assign dc_en         = (state != IDLE);
  assign sample_strobe = (state == RUN) && (tick == T_LAST);

  for (genvar k = 0; k < NPHASE; k++) begin : g_phase
    aqfp_phase_slice #(
      .OFFSET(phase_offset(k))
    ) u_slice (
      .clock    (clock),
      .reset    (reset),
      .run_next (run_next),
      .t_next   (tick_n),
      .xphase   (xphase[k])
    );
  end

endmodule

// File: tb/tb_aqfp_excite_gen.sv
// Directed bench for aqfp_excite_gen: cycle-by-cycle waveform checks against
// hand-derived timelines for the default configuration (P=8, WARMUP=8).
module tb_aqfp_excite_gen;

  logic        clock;
  logic        reset;
  logic        start;
  logic        stop;
  logic [15:0] burst_len;
  logic        dc_en;
  logic [3:0]  xphase;
  logic        sample_strobe;
  logic [15:0] cycle_cnt;
  logic        busy;
  logic        done;

  int checks = 0;
  int fails  = 0;

  // xphase per tick in the first period (phases switch on one by one) and in
  // every later period (all four phases running).
  logic [3:0] first_pat  [8] = '{4'b0001, 4'b0001, 4'b0011, 4'b0011,
                                 4'b0110, 4'b0110, 4'b1100, 4'b1100};
  logic [3:0] steady_pat [8] = '{4'b1001, 4'b1001, 4'b0011, 4'b0011,
                                 4'b0110, 4'b0110, 4'b1100, 4'b1100};

  aqfp_excite_gen dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .burst_len     (burst_len),
    .dc_en         (dc_en),
    .xphase        (xphase),
    .sample_strobe (sample_strobe),
    .cycle_cnt     (cycle_cnt),
    .busy          (busy),
    .done          (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkIdle(input string tag, input logic [15:0] exp_cnt);
    checkOutput({tag, " dc_en"}, dc_en, 0);
    checkOutput({tag, " xphase"}, xphase, 0);
    checkOutput({tag, " strobe"}, sample_strobe, 0);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " done"}, done, 0);
    checkOutput({tag, " cycle_cnt"}, cycle_cnt, exp_cnt);
  endtask

  // Cycle c counts from the first cycle after the edge that accepts start.
  // stop_cyc/restart_cyc drive stop/start high during that cycle; abort_cyc
  // fires an asynchronous reset in the middle of that cycle.
  task automatic applyStimulus(input logic [15:0] blen, input int n_per, input int stop_cyc,
                               input int restart_cyc, input int abort_cyc);
    int  drain_start;
    int  done_cyc;
    int  strobes;
    bit  settle_stop;
    settle_stop = (stop_cyc > 0) && (stop_cyc <= 8);
    drain_start = settle_stop ? (stop_cyc + 1) : (9 + 8 * n_per);
    done_cyc    = drain_start + 8;
    strobes     = 0;
    burst_len   = blen;
    start       = 1'b1;
    step();
    start     = 1'b0;
    burst_len = 16'd7;
    for (int c = 1; c <= done_cyc; c++) begin
      bit         in_run;
      int         t;
      int         per;
      logic [3:0] exp_x;
      int         exp_cnt;
      in_run  = (c >= 9) && (c < drain_start);
      t       = in_run ? ((c - 9) % 8) : 0;
      per     = in_run ? ((c - 9) / 8) : 0;
      exp_x   = in_run ? ((per == 0) ? first_pat[t] : steady_pat[t]) : 4'b0000;
      exp_cnt = in_run ? per : ((c < 9) ? 0 : n_per);
      checkOutput($sformatf("c%0d dc_en", c), dc_en, (c < done_cyc) ? 1 : 0);
      checkOutput($sformatf("c%0d busy", c), busy, (c < done_cyc) ? 1 : 0);
      checkOutput($sformatf("c%0d done", c), done, (c == done_cyc) ? 1 : 0);
      checkOutput($sformatf("c%0d xphase", c), xphase, exp_x);
      checkOutput($sformatf("c%0d strobe", c), sample_strobe, (in_run && t == 7) ? 1 : 0);
      checkOutput($sformatf("c%0d cycle_cnt", c), cycle_cnt, exp_cnt);
      if (sample_strobe) strobes++;
      if (c == abort_cyc) begin
        start = 1'b0;
        stop  = 1'b0;
        #3 reset = 1'b1;
        #1;
        checkOutput("async rst dc_en", dc_en, 0);
        checkOutput("async rst xphase", xphase, 0);
        checkOutput("async rst busy", busy, 0);
        checkOutput("async rst strobe", sample_strobe, 0);
        step();
        checkIdle("rst held", 16'd0);
        reset = 1'b0;
        step();
        checkIdle("rst released", 16'd0);
        return;
      end
      stop  = (c == stop_cyc);
      start = (c == restart_cyc);
      step();
    end
    stop  = 1'b0;
    start = 1'b0;
    checkOutput("strobe count", strobes, n_per);
    checkIdle("idle hold", 16'(n_per));
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    burst_len = 16'd0;
    #12;
    checkIdle("reset high", 16'd0);
    reset = 1'b0;
    step();
    checkIdle("reset low", 16'd0);

    $display("[TB] reset mid-stream, then start with stop");
    applyStimulus(16'd3, 3, 0, 0, 5);
    burst_len = 16'd1;
    start     = 1'b1;
    stop      = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    checkIdle("start+stop", 16'd0);
    step();
    checkIdle("start+stop later", 16'd0);

    $display("[TB] single period burst");
    applyStimulus(16'd1, 1, 0, 0, 0);

    $display("[TB] three period burst");
    applyStimulus(16'd3, 3, 0, 0, 0);

    $display("[TB] continuous burst stopped in period 5");
    applyStimulus(16'd0, 5, 44, 0, 0);

    $display("[TB] async reset mid-run, then fresh burst");
    applyStimulus(16'd1, 1, 0, 0, 12);
    applyStimulus(16'd1, 1, 0, 0, 0);

    $display("[TB] start during run ignored, stop during settle");
    applyStimulus(16'd2, 2, 0, 20, 0);
    applyStimulus(16'd2, 0, 3, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/aqfp_excite_gen.md
Name: aqfp_excite_gen

Overview:
- Synchronous controller that produces the multi-phase AC excitation and the DC bias enable for AQFP gate chains. Its outputs drive the xin/dcin bias inputs of chained buffer, splitter, majority and and/or cells.
- Sequence: DC bias settle, then a burst of quadrature excitation periods, then drain.
- Emits a sample strobe once per completed excitation period so the downstream capture logic knows when gate outputs are valid.

Parameters:
- NPHASE, 4, number of excitation phases.
- DIV, 2, clock cycles per phase offset. Period P = NPHASE*DIV; P must be even and ≥2.
- WARMUP, 8, clock cycles of DC-only bias before RUN and after RUN (drain).
- CW, 16, width of burst_len and cycle_cnt.

Ports:
- clock  in  1  sole clock; all logic rises on its posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a sequence; honoured only in IDLE.
- stop  in  1  request early termination.
- burst_len  in  CW  number of periods to run; 0 = continuous. Sampled when start is accepted.
- dc_en  out  1  DC bias enable (dcin drive).
- xphase  out  NPHASE  AC excitation phases (xin drive); registered.
- sample_strobe  out  1  one-cycle pulse in the last cycle of each period.
- cycle_cnt  out  CW  number of completed periods in the current burst.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on return to IDLE.

Behaviour:
- Reset is asynchronous. Outputs while reset is high and after release: dc_en=0, xphase=0, sample_strobe=0, cycle_cnt=0, busy=0, done=0, state=IDLE.
- States: IDLE, DC_SETTLE, RUN, DRAIN.
- IDLE:
  - stop has priority over start; start with stop in the same cycle is ignored.
  - start alone → DC_SETTLE, latch burst_len, clear cycle_cnt. dc_en and busy rise in the next cycle.
- DC_SETTLE: dc_en=1, xphase=0 for exactly WARMUP cycles, then → RUN with tick t=0. stop → DRAIN immediately.
- RUN:
  - tick t counts 0..P-1 and wraps.
  - Phase k is enabled from the first cycle of the burst where t==k*DIV; once enabled it stays enabled for the rest of the burst.
  - xphase[k] = enabled_k && ((t − k*DIV) mod P) < P/2.
  - At t==P-1: sample_strobe=1 and cycle_cnt increments; the new value is visible next cycle. cycle_cnt saturates at all-ones.
  - Exit to DRAIN at t==P-1 when either:
    - the post-increment count == latched burst_len (burst_len≠0), or
    - a stop is pending.
  - stop is latched in RUN and takes effect at the next t==P-1, including the current cycle if t==P-1.
- DRAIN:
  - Entered: all xphase drop to 0 in the same cycle.
  - dc_en stays 1 for WARMUP cycles, then → IDLE.
  - The first IDLE cycle shows done=1, busy=0, dc_en=0.
- cycle_cnt holds its value in IDLE until the next accepted start.
- start while busy is ignored.

Decomposition:
- Package aqfp_excite_pkg holds:
  - the state enumeration;
  - localparam P and HALF_P;
  - the function computing the phase offset k*DIV.
- Sub-module aqfp_phase_slice is instantiated NPHASE times. Each instance holds one phase's enable register and its mod-P half-period compare.

Test Plan:
1. Assert reset mid-stream, then release → all outputs 0 and IDLE. start pulsed with stop=1 → busy stays 0.
2. Defaults, burst_len=1, start sampled at edge 0:
   - dc_en=1 in cycles 1–24.
   - xphase in cycles 9–16 = 0001,0001,0011,0011,0110,0110,1100,1100.
   - sample_strobe in cycle 16; cycle_cnt=1 from cycle 17.
   - xphase=0 in cycles 17–24.
   - done=1 and busy=0 in cycle 25.
3. burst_len=3 → exactly 3 sample_strobes at cycles 16, 24, 32. The second period starts with xphase=1001. Final cycle_cnt=3, done in cycle 41.
4. burst_len=0 (continuous), stop pulsed at RUN t=3 of period 5 → RUN ends at that period's t=7, cycle_cnt=5, then DRAIN for 8 cycles and done.
5. Async reset asserted mid-RUN (between clock edges) → dc_en, xphase and busy go to 0 immediately. After release, a fresh start reproduces the scenario-2 waveform.
6. start re-asserted during RUN is ignored. stop during DC_SETTLE → xphase never nonzero, 8 drain cycles, done, cycle_cnt=0.
